// File: rtl/recovery_rf_restore_if.sv
// Bus between the restore sequencer, the recovery RF read ports and the core RF write ports.
// The sequencer side uses the master modport.
interface recovery_rf_restore_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DataWidth  = 32
);
  logic [ADDR_WIDTH-1:0] raddr_a_o, raddr_b_o;
  logic [DataWidth-1:0]  rdata_a_i, rdata_b_i;
  logic [ADDR_WIDTH-1:0] waddr_a_o, waddr_b_o;
  logic [DataWidth-1:0]  wdata_a_o, wdata_b_o;
  logic                  we_a_o, we_b_o;
  logic                  core_ready_i;

  modport master (
    output raddr_a_o, raddr_b_o,
    input  rdata_a_i, rdata_b_i,
    output waddr_a_o, wdata_a_o, we_a_o,
    output waddr_b_o, wdata_b_o, we_b_o,
    input  core_ready_i
  );

  modport slave (
    input  raddr_a_o, raddr_b_o,
    output rdata_a_i, rdata_b_i,
    input  waddr_a_o, wdata_a_o, we_a_o,
    input  waddr_b_o, wdata_b_o, we_b_o,
    output core_ready_i
  );
endinterface

// File: rtl/recovery_rf_restore.sv
// Replays the recovery RF into the core RF two registers per cycle, skipping R0,
// through a single registered write stage with a valid/ready handshake.
module recovery_rf_restore #(
  parameter int ADDR_WIDTH = 5,
  parameter int DataWidth  = 32,
  parameter int FPU        = 0,
  parameter int PULP_ZFINX = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  recovery_rf_restore_if.master bus
);

  localparam int NUM_LANES   = 2;
  localparam int NumWords    = 2 ** (ADDR_WIDTH - 1);
  localparam int NumTotWords = NumWords + ((FPU != 0 && PULP_ZFINX == 0) ? NumWords : 0);
  // One extra bit so cnt+1 / cnt+2 past the top of the space never wrap to a low address.
  localparam int CW          = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] TotW = CW'(NumTotWords);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_p1, cnt_p2;
  logic          capture, accept;

  logic [NUM_LANES-1:0]                 we_q;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] waddr_q;
  logic [NUM_LANES-1:0][DataWidth-1:0]  wdata_q;

  assign cnt_p1  = cnt_q + CW'(1);
  assign cnt_p2  = cnt_q + CW'(2);
  assign accept  = we_q[0] & bus.core_ready_i;
  // Lane A is always valid when the stage holds a pair, so it doubles as the stage-full flag.
  assign capture = (state_q == READ) && (!we_q[0] || bus.core_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= CW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    bus.raddr_a_o = '0;
    bus.raddr_b_o = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = CW'(1);
          state_d = READ;
        end
      end
      READ: begin
        busy_o        = 1'b1;
        bus.raddr_a_o = cnt_q[ADDR_WIDTH-1:0];
        bus.raddr_b_o = cnt_p1[ADDR_WIDTH-1:0];
        if (capture) begin
          cnt_d = cnt_p2;
          if (cnt_p2 >= TotW) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (accept || !we_q[0]) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write stage: loads on capture, clears on acceptance, otherwise holds bit-stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q[0]    <= 1'b1;
      we_q[1]    <= (cnt_p1 < TotW);
      waddr_q[0] <= cnt_q[ADDR_WIDTH-1:0];
      waddr_q[1] <= cnt_p1[ADDR_WIDTH-1:0];
      wdata_q[0] <= bus.rdata_a_i;
      wdata_q[1] <= bus.rdata_b_i;
    end else if (accept) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end
  end

  assign bus.we_a_o    = we_q[0];
  assign bus.waddr_a_o = waddr_q[0];
  assign bus.wdata_a_o = wdata_q[0];
  assign bus.we_b_o    = we_q[1];
  assign bus.waddr_b_o = waddr_q[1];
  assign bus.wdata_b_o = wdata_q[1];

endmodule

// File: tb/tb_recovery_rf_restore.sv
// Directed bench for recovery_rf_restore: default and FP-bank instances, recovery RF word i = 0xA5A50000+i.
module tb_recovery_rf_restore;
  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, core_ready;
  logic busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  recovery_rf_restore_if #(.ADDR_WIDTH(5), .DataWidth(32)) ifa ();
  recovery_rf_restore_if #(.ADDR_WIDTH(5), .DataWidth(32)) ifb ();

  recovery_rf_restore #(.ADDR_WIDTH(5), .DataWidth(32), .FPU(0), .PULP_ZFINX(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a), .bus(ifa.master));
  recovery_rf_restore #(.ADDR_WIDTH(5), .DataWidth(32), .FPU(1), .PULP_ZFINX(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b), .bus(ifb.master));

  // Recovery RF model: combinational read of word i = 0xA5A50000 + i
  assign ifa.rdata_a_i    = 32'hA5A5_0000 + 32'(ifa.raddr_a_o);
  assign ifa.rdata_b_i    = 32'hA5A5_0000 + 32'(ifa.raddr_b_o);
  assign ifb.rdata_a_i    = 32'hA5A5_0000 + 32'(ifb.raddr_a_o);
  assign ifb.rdata_b_i    = 32'hA5A5_0000 + 32'(ifb.raddr_b_o);
  assign ifa.core_ready_i = core_ready;
  assign ifb.core_ready_i = core_ready;

  int sel = 0;
  logic        o_we_a, o_we_b, o_busy, o_done;
  logic [4:0]  o_wa, o_wb, o_ra, o_rb;
  logic [31:0] o_da, o_db;
  always_comb begin
    if (sel == 0) begin
      o_we_a = ifa.we_a_o; o_we_b = ifa.we_b_o; o_wa = ifa.waddr_a_o; o_wb = ifa.waddr_b_o;
      o_da = ifa.wdata_a_o; o_db = ifa.wdata_b_o; o_ra = ifa.raddr_a_o; o_rb = ifa.raddr_b_o;
      o_busy = busy_a; o_done = done_a;
    end else begin
      o_we_a = ifb.we_a_o; o_we_b = ifb.we_b_o; o_wa = ifb.waddr_a_o; o_wb = ifb.waddr_b_o;
      o_da = ifb.wdata_a_o; o_db = ifb.wdata_b_o; o_ra = ifb.raddr_a_o; o_rb = ifb.raddr_b_o;
      o_busy = busy_b; o_done = done_b;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  bit          h_we_a [64];
  bit          h_we_b [64];
  int          h_wa   [64];
  int          h_wb   [64];
  int          h_ra   [64];
  logic [31:0] h_da   [64];
  logic [31:0] h_db   [64];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          busy_cnt, done_cnt, done_cyc, done_cyc2;

  task automatic set_start(input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  // Cycle c is the cycle after start edge c-1; mode 0 pulse, 1 repeat start in cycles 1..9, 2 hold through cycle 21
  task automatic sweep(input int ncyc, input int mode, input int stall_from, input int stall_len);
    wr_addr.delete(); wr_data.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; done_cyc2 = -1;
    for (int i = 0; i < 64; i++) begin
      h_we_a[i] = 0; h_we_b[i] = 0; h_wa[i] = 0; h_wb[i] = 0; h_ra[i] = 0; h_da[i] = '0; h_db[i] = '0;
    end
    @(negedge clk); set_start(1'b1); core_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      set_start((mode == 2 && c <= 21) || (mode == 1 && c <= 9));
      core_ready = !(c >= stall_from && c < stall_from + stall_len);
      @(negedge clk);
      h_we_a[c] = o_we_a; h_we_b[c] = o_we_b; h_wa[c] = int'(o_wa); h_wb[c] = int'(o_wb);
      h_ra[c] = int'(o_ra); h_da[c] = o_da; h_db[c] = o_db;
      if (o_we_a && core_ready) begin wr_addr.push_back(int'(o_wa)); wr_data.push_back(o_da); end
      if (o_we_b && core_ready) begin wr_addr.push_back(int'(o_wb)); wr_data.push_back(o_db); end
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c; else if (done_cyc2 < 0) done_cyc2 = c;
      end
      @(posedge clk); #1;
    end
    set_start(1'b0); core_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; core_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      n_checks++;
      if ({o_we_a, o_we_b, o_busy, o_done} !== 4'b0) begin
        n_fail++; $display("FAIL reset_ctrl dut%0d: got %b want 0000", s, {o_we_a, o_we_b, o_busy, o_done});
      end
      n_checks++;
      if ({o_wa, o_wb, o_ra, o_rb, o_da, o_db} !== 84'd0) begin
        n_fail++; $display("FAIL reset_bus dut%0d: got %h want 0", s, {o_wa, o_wb, o_ra, o_rb, o_da, o_db});
      end
    end
    sel = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    sel = 0;
    sweep(14, 0, 0, 0);
    n_checks++;
    if (wr_addr.size() != 15) begin n_fail++; $display("FAIL basic_count: got %0d want 15", wr_addr.size()); end
    for (int i = 0; i < 15 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i + 1 || wr_data[i] !== 32'hA5A5_0000 + 32'(i + 1)) begin
        n_fail++; $display("FAIL basic_write[%0d]: got addr %0d data %h want addr %0d data %h",
                           i, wr_addr[i], wr_data[i], i + 1, 32'hA5A5_0000 + 32'(i + 1));
      end
    end
    n_checks++;
    if (h_we_a[1] !== 1'b0 || h_ra[1] != 1) begin
      n_fail++; $display("FAIL basic_first_cycle: got we_a %b raddr_a %0d want 0 1", h_we_a[1], h_ra[1]);
    end
    for (int c = 2; c <= 8; c++) begin
      n_checks++;
      if (h_we_a[c] !== 1'b1 || h_we_b[c] !== 1'b1 || h_wa[c] != 2*c-3 || h_wb[c] != 2*c-2) begin
        n_fail++; $display("FAIL basic_pair c%0d: got %b%b (%0d,%0d) want 11 (%0d,%0d)",
                           c, h_we_a[c], h_we_b[c], h_wa[c], h_wb[c], 2*c-3, 2*c-2);
      end
    end
    n_checks++;
    if (h_we_a[9] !== 1'b1 || h_wa[9] != 15 || h_we_b[9] !== 1'b0) begin
      n_fail++; $display("FAIL basic_last: got we_a %b addr %0d we_b %b want 1 15 0", h_we_a[9], h_wa[9], h_we_b[9]);
    end
    n_checks++;
    if (busy_cnt != 9) begin n_fail++; $display("FAIL basic_busy: got %0d want 9", busy_cnt); end
    n_checks++;
    if (done_cyc != 10 || done_cnt != 1) begin
      n_fail++; $display("FAIL basic_done: got cycle %0d count %0d want 10 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_stall;
    sel = 0;
    sweep(16, 0, 4, 3);
    for (int c = 4; c <= 7; c++) begin
      n_checks++;
      if (h_we_a[c] !== 1'b1 || h_we_b[c] !== 1'b1 || h_wa[c] != 5 || h_wb[c] != 6 ||
          h_da[c] !== 32'hA5A5_0005 || h_db[c] !== 32'hA5A5_0006 || h_ra[c] != 7) begin
        n_fail++; $display("FAIL stall_hold c%0d: got %b%b (%0d,%0d) %h %h ra %0d want 11 (5,6) a5a50005 a5a50006 ra 7",
                           c, h_we_a[c], h_we_b[c], h_wa[c], h_wb[c], h_da[c], h_db[c], h_ra[c]);
      end
    end
    n_checks++;
    if (wr_addr.size() != 15) begin n_fail++; $display("FAIL stall_count: got %0d want 15", wr_addr.size()); end
    for (int i = 0; i < 15 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i + 1) begin n_fail++; $display("FAIL stall_order[%0d]: got %0d want %0d", i, wr_addr[i], i + 1); end
    end
    n_checks++;
    if (done_cyc != 13 || done_cnt != 1) begin
      n_fail++; $display("FAIL stall_done: got cycle %0d count %0d want 13 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_fpu;
    sel = 1;
    sweep(22, 0, 0, 0);
    n_checks++;
    if (wr_addr.size() != 31) begin n_fail++; $display("FAIL fpu_count: got %0d want 31", wr_addr.size()); end
    for (int i = 0; i < 31 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i + 1 || wr_data[i] !== 32'hA5A5_0000 + 32'(i + 1)) begin
        n_fail++; $display("FAIL fpu_write[%0d]: got addr %0d data %h want addr %0d", i, wr_addr[i], wr_data[i], i + 1);
      end
    end
    n_checks++;
    if (h_wa[9] != 15 || h_wb[9] != 16 || h_we_b[9] !== 1'b1 || h_db[9] !== 32'hA5A5_0010) begin
      n_fail++; $display("FAIL fpu_bank_pair: got (%0d,%0d) we_b %b db %h want (15,16) 1 a5a50010",
                         h_wa[9], h_wb[9], h_we_b[9], h_db[9]);
    end
    n_checks++;
    if (h_wa[17] != 31 || h_we_a[17] !== 1'b1 || h_we_b[17] !== 1'b0) begin
      n_fail++; $display("FAIL fpu_last: got addr %0d we %b%b want 31 10", h_wa[17], h_we_a[17], h_we_b[17]);
    end
    n_checks++;
    if (done_cyc != 18 || done_cnt != 1) begin
      n_fail++; $display("FAIL fpu_done: got cycle %0d count %0d want 18 1", done_cyc, done_cnt);
    end
    sel = 0;
  endtask

  task automatic test_start_ignored;
    sel = 0;
    sweep(14, 1, 0, 0);
    n_checks++;
    if (done_cnt != 1 || done_cyc != 10) begin
      n_fail++; $display("FAIL ignore_done: got count %0d cycle %0d want 1 10", done_cnt, done_cyc);
    end
    n_checks++;
    if (wr_addr.size() != 15 || busy_cnt != 9) begin
      n_fail++; $display("FAIL ignore_writes: got %0d writes busy %0d want 15 9", wr_addr.size(), busy_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    sel = 0; dones = 0;
    @(negedge clk); start_a = 1'b1; core_ready = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_we_a !== 1'b1 || o_wa != 5'd7 || o_wb != 5'd8) begin
      n_fail++; $display("FAIL rst_pending: got we_a %b (%0d,%0d) want 1 (7,8)", o_we_a, o_wa, o_wb);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_we_a, o_we_b, o_busy, o_done, o_wa, o_wb, o_ra, o_rb, o_da, o_db} !== 88'd0) begin
      n_fail++; $display("FAIL rst_async: got %h want 0", {o_we_a, o_we_b, o_busy, o_done, o_wa, o_wb, o_ra, o_rb, o_da, o_db});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses want 0", dones); end
    sweep(14, 0, 0, 0);
    n_checks++;
    if (wr_addr.size() != 15 || wr_addr[0] != 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL rst_restart: got %0d writes first %0d dones %0d want 15 1 1",
                         wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : -1, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    sel = 0;
    sweep(24, 2, 0, 0);
    n_checks++;
    if (done_cnt != 2 || done_cyc != 10 || done_cyc2 != 21) begin
      n_fail++; $display("FAIL b2b_done: got count %0d cycles %0d %0d want 2 10 21", done_cnt, done_cyc, done_cyc2);
    end
    n_checks++;
    if (wr_addr.size() != 30) begin n_fail++; $display("FAIL b2b_count: got %0d want 30", wr_addr.size()); end
    for (int i = 0; i < 30 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != (i % 15) + 1) begin
        n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, wr_addr[i], (i % 15) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_fpu();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
